// File: rtl/openframe_gpio_pkg.sv
// Shared constants and the event record for the openframe GPIO event reader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package openframe_gpio_pkg;

    localparam int NPADS_DEFAULT      = 44;
    localparam int PAD_IDX_W          = 6;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // One queued level-change event: which pad, and the level it settled to.
    typedef struct packed {
        logic [PAD_IDX_W-1:0] pad;
        logic                 level;
    } evt_t;

endpackage

// File: rtl/openframe_gpio_evt_fifo.sv
// Event queue between the pad priority encoder and the consumer.
// Latency: a pushed event is visible at the head one cycle after the push.
// Backpressure: push accepted when not full, or when full and the head pops in the same cycle.
module openframe_gpio_evt_fifo
    import openframe_gpio_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_push_vld,
    output logic o_push_rdy,
    input  evt_t i_push_dat,
    output logic o_pop_vld,
    input  logic i_pop_rdy,
    output evt_t o_pop_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    evt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_count == CW'(DEPTH));
    assign o_pop_vld  = (r_count != '0);
    assign o_push_rdy = !w_full || i_pop_rdy;
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = o_pop_vld && i_pop_rdy;
    // Head is forced to zero when empty so stale storage never leaks after reset.
    assign o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;

    // Storage write; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/openframe_gpio_event_reader.sv
// Synchronises and debounces openframe GPIO pads and queues per-pad level-change events.
// Latency: with debounce_div=0, level changes 3 edges after sync1 capture; event valid one edge later.
// Backpressure: full queue holds pending bits; a repeat toggle on a pending pad coalesces and sets overflow.
module openframe_gpio_event_reader
    import openframe_gpio_pkg::*;
#(
    parameter int NPADS      = NPADS_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [NPADS-1:0]     gpio_in,
    input  logic [NPADS-1:0]     pad_en,
    input  logic [7:0]           debounce_div,
    output logic [NPADS-1:0]     level,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [PAD_IDX_W-1:0] evt_pad,
    output logic                 evt_level,
    output logic                 overflow,
    input  logic                 clear_ovf
);

    logic [NPADS-1:0]     r_sync1;
    logic [NPADS-1:0]     r_sync2;
    logic [NPADS-1:0]     r_samp;
    logic [NPADS-1:0]     r_level;
    logic [NPADS-1:0]     r_pending;
    logic [7:0]           r_presc;
    logic                 r_ovf;

    logic                 w_tick;
    logic [NPADS-1:0]     w_change;
    logic [NPADS-1:0]     w_push_clr;
    logic                 w_coalesce;
    logic                 w_sel_found;
    logic [PAD_IDX_W-1:0] w_sel_idx;
    logic                 w_push_rdy;
    logic                 w_push_fire;
    evt_t                 w_push_dat;
    evt_t                 w_head;

    // Two-flop synchroniser on the raw pad levels.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-tick prescaler; >= keeps it from running away if the divider shrinks mid-count.
    assign w_tick = (r_presc >= debounce_div);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    // A pad changes only if enabled and the synchronised value agreed on two consecutive ticks.
    assign w_change = {NPADS{w_tick}} & pad_en & ~(r_sync2 ^ r_samp) & (r_sync2 ^ r_level);

    // Lowest-index pending pad wins the single push slot each cycle.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (r_pending[i] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = PAD_IDX_W'(i);
            end
        end
    end

    assign w_push_fire      = w_sel_found && w_push_rdy;
    assign w_push_clr       = w_push_fire ? (NPADS'(1) << w_sel_idx) : '0;
    assign w_push_dat.pad   = w_sel_idx;
    assign w_push_dat.level = r_level[w_sel_idx];
    // A toggle on a pad whose previous change is still unqueued merges into one event.
    assign w_coalesce       = |(w_change & r_pending & ~w_push_clr);

    // Debounce sample, debounced level and pending-event bookkeeping.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_samp    <= '0;
            r_level   <= '0;
            r_pending <= '0;
        end else begin
            if (w_tick) begin
                r_samp <= r_sync2;
            end
            r_level   <= r_level ^ w_change;
            r_pending <= (r_pending & ~w_push_clr) | w_change;
        end
    end

    // Sticky overflow; a same-cycle clear beats a new coalesce.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ovf <= 1'b0;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end else if (w_coalesce) begin
            r_ovf <= 1'b1;
        end
    end

    openframe_gpio_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .resetb     (resetb),
        .i_push_vld (w_sel_found),
        .o_push_rdy (w_push_rdy),
        .i_push_dat (w_push_dat),
        .o_pop_vld  (evt_valid),
        .i_pop_rdy  (evt_ready),
        .o_pop_dat  (w_head)
    );

    assign level     = r_level;
    assign evt_pad   = w_head.pad;
    assign evt_level = w_head.level;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_openframe_gpio_event_reader.sv
// Self-checking bench for openframe_gpio_event_reader against a queue-based reference model.
// Latency: n/a.
// Backpressure: consumer ready is driven per scenario.
module tb_openframe_gpio_event_reader;

    localparam int NP = 44;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic [NP-1:0] gpio_in = '0;
    logic [NP-1:0] pad_en = '1;
    logic [7:0]    debounce_div = 8'd0;
    logic [NP-1:0] level;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [5:0]    evt_pad;
    logic          evt_level;
    logic          overflow;
    logic          clear_ovf = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    openframe_gpio_event_reader #(.NPADS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .gpio_in      (gpio_in),
        .pad_en       (pad_en),
        .debounce_div (debounce_div),
        .level        (level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_pad      (evt_pad),
        .evt_level    (evt_level),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    // Events the DUT hands over, with the cycle they were accepted in.
    logic [6:0] dut_log [$];
    int         dut_cyc [$];
    int         cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (resetb && evt_valid && evt_ready) begin
            dut_log.push_back({evt_pad, evt_level});
            dut_cyc.push_back(cyc);
        end
    end

    // Reference model: synchroniser as a delay line, debounce as "same value on two
    // consecutive ticks", pending as a set scanned low to high, queue as an SV queue.
    logic [NP-1:0] m_s1, m_s2, m_samp, m_lvl, m_pend;
    int            m_cnt;
    bit            m_ovf;
    logic [6:0]    m_q [$];
    logic [6:0]    mdl_log [$];

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_s1 = '0; m_s2 = '0; m_samp = '0; m_lvl = '0; m_pend = '0;
            m_cnt = 0; m_ovf = 0; m_q.delete();
        end else begin
            bit tick, pop, found, coal;
            int sel;
            tick = ((m_cnt % (int'(debounce_div) + 1)) == int'(debounce_div));
            m_cnt++;
            pop = (m_q.size() > 0) && evt_ready;
            found = 0; sel = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_pend[i] && !found) begin found = 1; sel = i; end
            end
            if (pop) mdl_log.push_back(m_q.pop_front());
            if (found && (m_q.size() < DEPTH || pop)) begin
                m_q.push_back({6'(sel), m_lvl[sel]});
                m_pend[sel] = 1'b0;
            end
            coal = 0;
            if (tick) begin
                for (int i = 0; i < NP; i++) begin
                    if (pad_en[i] && m_s2[i] == m_samp[i] && m_s2[i] != m_lvl[i]) begin
                        m_lvl[i] = m_s2[i];
                        if (m_pend[i]) coal = 1;
                        m_pend[i] = 1'b1;
                    end
                end
                m_samp = m_s2;
            end
            m_s2 = m_s1;
            m_s1 = gpio_in;
            m_ovf = clear_ovf ? 1'b0 : (m_ovf | coal);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] div);
        gpio_in = '0; pad_en = '1; evt_ready = 0; clear_ovf = 0;
        debounce_div = div;
        resetb = 0;
        step(2);
        resetb = 1;
        dut_log.delete(); dut_cyc.delete(); mdl_log.delete();
    endtask

    task automatic test_reset;
        do_reset(8'd0);
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_pad !== 6'd0) $display("FAIL reset_pad got %0d want 0", evt_pad); else n_pass++;
        n_checks++; if (evt_level !== 1'b0) $display("FAIL reset_evt_level got %b want 0", evt_level); else n_pass++;
        n_checks++; if (level !== '0) $display("FAIL reset_level got %h want 0", level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_latency;
        do_reset(8'd0);
        gpio_in[5] = 1'b1;
        step(3); // after edge N+2
        n_checks++; if (level[5] !== 1'b0) $display("FAIL lat_level_early got %b want 0", level[5]); else n_pass++;
        step(1); // after edge N+3
        n_checks++; if (level[5] !== 1'b1) $display("FAIL lat_level got %b want 1", level[5]); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL lat_valid_early got %b want 0", evt_valid); else n_pass++;
        step(1); // after edge N+4
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL lat_valid got %b want 1", evt_valid); else n_pass++;
        n_checks++; if ({evt_pad, evt_level} !== {6'd5, 1'b1})
            $display("FAIL lat_event got pad %0d lvl %b want pad 5 lvl 1", evt_pad, evt_level); else n_pass++;
        evt_ready = 1;
        step(3);
        n_checks++; if (dut_log.size() != 1) $display("FAIL lat_count got %0d want 1", dut_log.size()); else n_pass++;
    endtask

    task automatic test_glitch;
        do_reset(8'd3);
        step(5);
        gpio_in[7] = 1'b1;
        step(3);
        gpio_in[7] = 1'b0;
        step(16);
        n_checks++; if (level[7] !== 1'b0) $display("FAIL glitch_level got %b want 0", level[7]); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL glitch_valid got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_order;
        logic [6:0] exp [3];
        exp[0] = {6'd0, 1'b1}; exp[1] = {6'd3, 1'b1}; exp[2] = {6'd40, 1'b1};
        do_reset(8'd0);
        evt_ready = 1;
        gpio_in[0] = 1; gpio_in[3] = 1; gpio_in[40] = 1;
        step(12);
        n_checks++; if (dut_log.size() != 3) $display("FAIL order_count got %0d want 3", dut_log.size()); else n_pass++;
        for (int i = 0; i < 3 && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== exp[i])
                $display("FAIL order_evt%0d got %h want %h", i, dut_log[i], exp[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (dut_cyc[i] != dut_cyc[i-1] + 1)
                    $display("FAIL order_gap%0d got %0d want %0d", i, dut_cyc[i], dut_cyc[i-1] + 1); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure;
        int pads [6] = '{1, 2, 10, 20, 30, 43};
        do_reset(8'd0);
        foreach (pads[k]) gpio_in[pads[k]] = 1'b1;
        step(12);
        n_checks++; if (evt_valid !== 1'b1 || {evt_pad, evt_level} !== {6'd1, 1'b1})
            $display("FAIL bp_head got v%b pad %0d want v1 pad 1", evt_valid, evt_pad); else n_pass++;
        evt_ready = 1;
        step(12);
        n_checks++; if (dut_log.size() != 6) $display("FAIL bp_count got %0d want 6", dut_log.size()); else n_pass++;
        for (int i = 0; i < 6 && i < dut_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== {6'(pads[i]), 1'b1})
                $display("FAIL bp_evt%0d got %h want %h", i, dut_log[i], {6'(pads[i]), 1'b1}); else n_pass++;
        end
        n_checks++; if (overflow !== 1'b0) $display("FAIL bp_ovf got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_coalesce;
        do_reset(8'd0);
        for (int p = 1; p <= 4; p++) gpio_in[p] = 1'b1;
        step(10);
        gpio_in[9] = 1'b1;
        step(6);
        n_checks++; if (level[9] !== 1'b1) $display("FAIL coal_rise got %b want 1", level[9]); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL coal_ovf_early got %b want 0", overflow); else n_pass++;
        gpio_in[9] = 1'b0;
        step(6);
        n_checks++; if (overflow !== 1'b1) $display("FAIL coal_ovf got %b want 1", overflow); else n_pass++;
        evt_ready = 1;
        step(10);
        n_checks++; if (dut_log.size() != 5) $display("FAIL coal_count got %0d want 5", dut_log.size()); else n_pass++;
        if (dut_log.size() == 5) begin
            n_checks++; if (dut_log[4] !== {6'd9, 1'b0})
                $display("FAIL coal_evt got %h want %h", dut_log[4], {6'd9, 1'b0}); else n_pass++;
        end
        clear_ovf = 1;
        step(1);
        clear_ovf = 0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL coal_clear got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset(8'd0);
        gpio_in[11] = 1; gpio_in[12] = 1; gpio_in[13] = 1;
        step(10);
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL rmid_queued got %b want 1", evt_valid); else n_pass++;
        resetb = 0;
        gpio_in[12] = 0;
        #1;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", evt_valid); else n_pass++;
        step(2);
        resetb = 1;
        dut_log.delete(); dut_cyc.delete(); mdl_log.delete();
        evt_ready = 1;
        step(12);
        n_checks++; if (dut_log.size() != 2) $display("FAIL rmid_count got %0d want 2", dut_log.size()); else n_pass++;
        if (dut_log.size() == 2) begin
            n_checks++; if (dut_log[0] !== {6'd11, 1'b1} || dut_log[1] !== {6'd13, 1'b1})
                $display("FAIL rmid_evts got %h %h want %h %h", dut_log[0], dut_log[1], {6'd11, 1'b1}, {6'd13, 1'b1});
            else n_pass++;
        end
    endtask

    task automatic test_random;
        do_reset(8'($urandom_range(0, 3)));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, NP-1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) pad_en[$urandom_range(0, NP-1)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 2) != 0);
            clear_ovf = ($urandom_range(0, 63) == 0);
            step(1);
            n_checks++; if (evt_valid !== (m_q.size() != 0))
                $display("FAIL rnd_valid c%0d got %b want %b", c, evt_valid, m_q.size() != 0); else n_pass++;
            if (m_q.size() != 0) begin
                n_checks++; if ({evt_pad, evt_level} !== m_q[0])
                    $display("FAIL rnd_head c%0d got %h want %h", c, {evt_pad, evt_level}, m_q[0]); else n_pass++;
            end
            n_checks++; if (level !== m_lvl) $display("FAIL rnd_level c%0d got %h want %h", c, level, m_lvl); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, m_ovf); else n_pass++;
        end
        evt_ready = 1; clear_ovf = 0; pad_en = '1;
        step(80);
        n_checks++; if (dut_log.size() != mdl_log.size())
            $display("FAIL rnd_total got %0d want %0d", dut_log.size(), mdl_log.size()); else n_pass++;
        for (int i = 0; i < dut_log.size() && i < mdl_log.size(); i++) begin
            n_checks++; if (dut_log[i] !== mdl_log[i])
                $display("FAIL rnd_evt%0d got %h want %h", i, dut_log[i], mdl_log[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_order();
        test_backpressure();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/openframe_gpio_event_reader.md
OPENFRAME_GPIO_EVENT_READER -- requirements
Module: openframe_gpio_event_reader

Interface
REQ-001 Parameter NPADS, default 44: number of openframe GPIO pads observed.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue depth, power of two.
REQ-003 clk  input  1: single block clock.
REQ-004 resetb  input  1: asynchronous active-low reset.
REQ-005 gpio_in  input  NPADS: raw pad input levels, asynchronous to clk.
REQ-006 pad_en  input  NPADS: per-pad enable; a disabled pad never generates events and its level holds.
REQ-007 debounce_div  input  8: sample-tick period minus one, in clk cycles.
REQ-008 level  output  NPADS: debounced pad levels.
REQ-009 evt_valid  output  1: event available at queue head.
REQ-010 evt_ready  input  1: consumer accepts head event when evt_valid and evt_ready are both high.
REQ-011 evt_pad  output  6: index of the pad at queue head.
REQ-012 evt_level  output  1: new debounced level of that pad.
REQ-013 overflow  output  1: sticky flag, one or more events coalesced.
REQ-014 clear_ovf  input  1: synchronous clear of overflow.

Function
REQ-015 Each gpio_in bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-016 The prescaler SHALL count 0..debounce_div and assert tick for one cycle on reaching debounce_div, then wrap to 0; debounce_div=0 gives tick every cycle.
REQ-017 On tick, samp[i] SHALL load sync2[i].
REQ-018 On tick, if pad_en[i], sync2[i]==samp[i], and sync2[i]!=level[i], then level[i] SHALL take sync2[i] and pending[i] SHALL be set.
REQ-019 Latency with debounce_div=0: input stable from sync1 capture at edge N -> level updates at edge N+3 -> evt_valid high after edge N+4.
REQ-020 A single-tick glitch (sync2 differs from samp) SHALL NOT change level.
REQ-021 Each cycle the FIFO is not full, the lowest-index set pending bit SHALL be pushed (pad index, current level) and cleared; at most one push per cycle.
REQ-022 If pending[i] is already set when level[i] toggles again, pending SHALL stay set, no second entry SHALL be produced, and overflow SHALL be set.
REQ-023 When the FIFO is full, pending bits SHALL be held, not dropped; only REQ-022 coalescing loses information.
REQ-024 Pop on evt_valid&&evt_ready; simultaneous push and pop when full SHALL both succeed, and occupancy SHALL stay at FIFO_DEPTH.
REQ-025 evt_pad/evt_level SHALL be stable while evt_valid is high and evt_ready is low.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-027 clear_ovf SHALL take priority over a same-cycle overflow set.
REQ-028 Deasserting pad_en[i] SHALL NOT clear an already set pending[i].

Reset
REQ-029 On resetb low, SHALL clear sync1, sync2, samp, level, pending, prescaler, FIFO pointers, occupancy, and overflow; evt_valid=0, evt_pad=0, evt_level=0.
REQ-030 Reset asserted mid-operation SHALL discard queued events; after release, pads already high SHALL produce rising events per REQ-018.

Structure
REQ-031 Package openframe_gpio_pkg SHALL hold NPADS_DEFAULT=44, PAD_IDX_W=6, FIFO_DEPTH_DEFAULT=4, and the event record type {pad, level}.
REQ-032 The queue SHALL be sub-module openframe_gpio_evt_fifo (valid/ready, same clk/resetb); the synchronizer, debounce logic, and priority encoder stay in the top level.

Verification
REQ-033 debounce_div=0, gpio_in[5] 0->1 and held -> level[5]=1 at edge N+3; one event {pad=5, level=1} with evt_valid after edge N+4.
REQ-034 debounce_div=3, gpio_in[7] high for 3 clk cycles and then low -> no level change, no event.
REQ-035 gpio_in[0], [3], [40] rise in the same cycle with evt_ready=1 -> events appear in order pads 0, 3, 40 on consecutive cycles.
REQ-036 evt_ready=0, 6 pads rise -> 4 events queued; after evt_ready=1, all 6 are delivered; overflow=0.
REQ-037 evt_ready=0, FIFO full, pad 9 rises then falls -> one event {9, 0}, overflow=1; clear_ovf -> overflow=0.
REQ-038 resetb pulsed low with 3 events queued -> evt_valid=0 immediately; after release, only pads currently high report rising events.
